// File: rtl/ac_sweep_pkg.sv
// Shared types and default widths for the AC sweep sequencer.
package ac_sweep_pkg;

  localparam int FW_DEF  = 32;
  localparam int DW_DEF  = 16;
  localparam int NPW_DEF = 10;
  localparam int SW_DEF  = 16;
  localparam int AW_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_EMIT    = 3'd4,
    ST_STEP    = 3'd5,
    ST_DONE    = 3'd6
  } sweep_state_t;

endpackage

// File: rtl/sweep_accum.sv
// Per-point sample counter and signed accumulator; 'reached' flags the sample
// that completes the programmed count so the FSM can leave MEASURE on that edge.
module sweep_accum
  import ac_sweep_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        enable,
  input  logic [AW-1:0]               n_avg,
  input  logic signed [DW-1:0]        data,
  output logic signed [DW+AW-1:0]     sum,
  output logic                        reached
);

  logic [AW-1:0] cnt;
  logic [AW-1:0] n_eff;
  logic [AW:0]   cnt_inc;

  assign n_eff   = (n_avg == '0) ? AW'(1) : n_avg;
  assign cnt_inc = {1'b0, cnt} + (AW+1)'(1);
  assign reached = enable && (cnt_inc >= {1'b0, n_eff});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sum <= '0;
    end else if (clear) begin
      cnt <= '0;
      sum <= '0;
    end else if (enable) begin
      cnt <= cnt_inc[AW-1:0];
      sum <= sum + $signed({{AW{data[DW-1]}}, data});
    end
  end

endmodule

// File: rtl/ac_sweep_sequencer.sv
// Steps a stimulus source through one frequency sweep, settling and averaging
// measurement samples at each point and handing one summed result per point downstream.
module ac_sweep_sequencer
  import ac_sweep_pkg::*;
#(
  parameter int FW  = FW_DEF,
  parameter int DW  = DW_DEF,
  parameter int NPW = NPW_DEF,
  parameter int SW  = SW_DEF,
  parameter int AW  = AW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [FW-1:0]           f_start,
  input  logic [FW-1:0]           f_step,
  input  logic [NPW-1:0]          n_points,
  input  logic [SW-1:0]           settle_cycles,
  input  logic [AW-1:0]           n_avg,
  output logic [FW-1:0]           src_freq,
  output logic                    src_en,
  output logic                    meas_req,
  input  logic                    meas_valid,
  input  logic signed [DW-1:0]    meas_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [DW+AW-1:0] res_data,
  output logic [NPW-1:0]          res_index,
  output logic                    busy,
  output logic                    done
);

  sweep_state_t state, nxt;

  logic [FW-1:0]  f_start_q, f_step_q;
  logic [NPW-1:0] n_points_q, idx;
  logic [SW-1:0]  settle_q, settle_cnt;
  logic [AW-1:0]  n_avg_q;
  logic           start_ok, last_point, acc_clear, acc_en, acc_reached;

  assign start_ok   = (state == ST_IDLE) && start && !abort;
  assign last_point = (idx == n_points_q - NPW'(1));
  assign acc_clear  = (state == ST_SETTLE) && (settle_cnt == '0) && !abort;
  // abort discards any sample landing in the same cycle
  assign acc_en     = (state == ST_MEASURE) && meas_valid && !abort;
  assign res_index  = idx;

  sweep_accum #(.DW(DW), .AW(AW)) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (acc_clear),
    .enable  (acc_en),
    .n_avg   (n_avg_q),
    .data    (meas_data),
    .sum     (res_data),
    .reached (acc_reached)
  );

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start && (n_points != '0)) nxt = ST_LOAD;
        ST_LOAD:    nxt = ST_SETTLE;
        ST_SETTLE:  if (settle_cnt == '0) nxt = ST_MEASURE;
        ST_MEASURE: if (acc_reached) nxt = ST_EMIT;
        ST_EMIT:    if (res_ready) nxt = last_point ? ST_DONE : ST_STEP;
        ST_STEP:    nxt = ST_SETTLE;
        ST_DONE:    nxt = ST_IDLE;
        default:    nxt = ST_IDLE;
      endcase
    end
  end

  // Sweep configuration is captured once per accepted start
  always_ff @(posedge clk) begin
    if (start_ok) begin
      f_start_q  <= f_start;
      f_step_q   <= f_step;
      n_points_q <= n_points;
      settle_q   <= settle_cycles;
      n_avg_q    <= n_avg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      meas_req   <= 1'b0;
      res_valid  <= 1'b0;
      done       <= 1'b0;
      src_en     <= 1'b0;
      src_freq   <= '0;
      idx        <= '0;
      settle_cnt <= '0;
    end else begin
      state     <= nxt;
      busy      <= (nxt != ST_IDLE);
      meas_req  <= (nxt == ST_MEASURE);
      res_valid <= (nxt == ST_EMIT);
      done      <= (nxt == ST_DONE) || (start_ok && (n_points == '0));
      if (abort) begin
        src_en <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            src_freq   <= f_start_q;
            idx        <= '0;
            src_en     <= 1'b1;
            settle_cnt <= settle_q;
          end
          ST_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
          ST_EMIT:   if (res_ready && last_point) src_en <= 1'b0;
          ST_STEP: begin
            src_freq   <= src_freq + f_step_q;
            idx        <= idx + NPW'(1);
            settle_cnt <= settle_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac_sweep_sequencer.sv
// Randomized bench for ac_sweep_sequencer with a queue-based point/sample model.
`timescale 1ns/1ps
module tb_ac_sweep_sequencer;
  localparam int FW = 32, DW = 16, NPW = 10, SW = 16, AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [FW-1:0] f_start = '0, f_step = '0;
  logic [NPW-1:0] n_points = '0;
  logic [SW-1:0] settle_cycles = '0;
  logic [AW-1:0] n_avg = '0;
  logic [FW-1:0] src_freq;
  logic src_en, meas_req, res_valid, busy, done;
  logic meas_valid = 1'b0, res_ready = 1'b0;
  logic signed [DW-1:0] meas_data = '0;
  logic signed [DW+AW-1:0] res_data;
  logic [NPW-1:0] res_index;

  always #5 clk = ~clk;

  ac_sweep_sequencer #(.FW(FW), .DW(DW), .NPW(NPW), .SW(SW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_points(n_points),
    .settle_cycles(settle_cycles), .n_avg(n_avg),
    .src_freq(src_freq), .src_en(src_en), .meas_req(meas_req),
    .meas_valid(meas_valid), .meas_data(meas_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_index(res_index), .busy(busy), .done(done)
  );

  int checks = 0, failures = 0;

  // Observations of one sweep and the model's expectation per point
  logic signed [DW+AW-1:0] obs_data[$];
  int obs_idx[$];
  logic [FW-1:0] obs_freq[$];
  longint exp_sum[$];
  int samp_cnt[$];
  int done_cyc, done_cnt, first_meas_cyc, busy_fall_cyc, stall_bad, rv_seen;
  bit src_en_seen, timed_out, post_abort_clear;

  task automatic run_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] fst,
                           input int np, input int s, input int na,
                           input int vmode, input int rmode, input int stall_len,
                           input int dval, input bit drand, input bit abort_in_meas);
    longint cur[$];
    longint acc;
    bit prev_meas = 0, have_prev = 0, alt = 0, seen_busy = 0, v, rdy;
    int stall = 0, neff, abort_cyc = -1;
    logic signed [DW-1:0] d;
    logic signed [DW+AW-1:0] pdata = '0;
    logic [NPW-1:0] pidx = '0;
    logic [FW-1:0] pfreq = '0;
    obs_data.delete(); obs_idx.delete(); obs_freq.delete();
    exp_sum.delete(); samp_cnt.delete();
    done_cyc = -1; done_cnt = 0; first_meas_cyc = -1; busy_fall_cyc = -1;
    stall_bad = 0; rv_seen = 0; src_en_seen = 0; timed_out = 0; post_abort_clear = 0;
    neff = (na == 0) ? 1 : na;
    @(negedge clk);
    f_start = fs; f_step = fst; n_points = NPW'(np);
    settle_cycles = SW'(s); n_avg = AW'(na);
    start = 1'b1; abort = 1'b0; res_ready = 1'b0; meas_valid = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      // Scramble config so any late use of the live inputs shows up
      f_start = $urandom; f_step = $urandom; n_points = NPW'($urandom);
      settle_cycles = SW'($urandom); n_avg = AW'($urandom);
      if (c == abort_cyc + 1) post_abort_clear = !busy && !meas_req && !res_valid && !src_en;
      if (src_en) src_en_seen = 1;
      if (done) begin done_cnt++; done_cyc = c; end
      if (res_valid) rv_seen++;
      if (meas_req && !prev_meas) begin
        cur.delete();
        if (first_meas_cyc < 0) first_meas_cyc = c;
      end
      if (!meas_req && prev_meas) begin
        acc = 0;
        for (int k = 0; k < cur.size() && k < neff; k++) acc += cur[k];
        exp_sum.push_back(acc);
        samp_cnt.push_back(cur.size());
      end
      prev_meas = meas_req;
      if (meas_req) begin
        if (abort_in_meas && abort_cyc < 0 && cur.size() >= 2) begin
          abort = 1'b1; abort_cyc = c;
        end
        case (vmode)
          0: v = 1;
          1: begin v = alt; alt = !alt; end
          default: v = ($urandom % 2) == 1;
        endcase
        d = drand ? DW'($urandom) : DW'(dval);
        meas_valid = v; meas_data = d;
        if (v) cur.push_back(longint'(d));
      end else begin
        meas_valid = ($urandom % 2) == 1;
        meas_data = DW'($urandom);
      end
      if (res_valid) begin
        if (have_prev && (res_data !== pdata || res_index !== pidx || src_freq !== pfreq))
          stall_bad++;
        case (rmode)
          0: rdy = 1;
          1: rdy = (stall >= stall_len);
          default: rdy = ($urandom % 2) == 1;
        endcase
        res_ready = rdy;
        if (rdy) begin
          obs_data.push_back(res_data); obs_idx.push_back(int'(res_index));
          obs_freq.push_back(src_freq);
          have_prev = 0; stall = 0;
        end else begin
          have_prev = 1; pdata = res_data; pidx = res_index; pfreq = src_freq; stall++;
        end
      end else begin
        res_ready = ($urandom % 2) == 1;
        have_prev = 0;
      end
      if (busy) seen_busy = 1;
      if (!busy && (seen_busy || done_cnt > 0) && c >= 3) begin
        busy_fall_cyc = c;
        break;
      end
    end
    if (busy_fall_cyc < 0) timed_out = 1;
    meas_valid = 1'b0; res_ready = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({src_freq, src_en, meas_req, res_valid, res_data, res_index, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got src_freq=%0d src_en=%0b meas_req=%0b res_valid=%0b res_data=%0d res_index=%0d busy=%0b done=%0b, want all 0",
               src_freq, src_en, meas_req, res_valid, res_data, res_index, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, src_en, done, meas_req} !== 4'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%0b src_en=%0b done=%0b meas_req=%0b, want 0", busy, src_en, done, meas_req);
    end
  endtask

  task automatic test_basic;
    run_sweep(32'd1000, 32'd250, 3, 2, 4, 0, 0, 0, 5, 0, 0);
    checks++;
    if (timed_out || obs_data.size() != 3 || samp_cnt.size() != 3) begin
      failures++;
      $display("FAIL basic_count: results=%0d timeout=%0b, want 3 results", obs_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_data[i] !== 24'sd20 || obs_idx[i] != i || obs_freq[i] !== 32'(1000 + 250 * i)) begin
          failures++;
          $display("FAIL basic_point%0d: data=%0d idx=%0d freq=%0d, want 20 %0d %0d",
                   i, obs_data[i], obs_idx[i], obs_freq[i], i, 1000 + 250 * i);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 28 || busy_fall_cyc != 29) begin
      failures++;
      $display("FAIL basic_timing: done_cnt=%0d done_cyc=%0d busy_fall=%0d, want 1 28 29", done_cnt, done_cyc, busy_fall_cyc);
    end
    checks++;
    if (first_meas_cyc != 5) begin
      failures++;
      $display("FAIL basic_meas_req_rise: cycle=%0d, want 5", first_meas_cyc);
    end
  endtask

  task automatic test_backpressure;
    run_sweep(32'd7, 32'd3, 2, 1, 3, 1, 1, 7, -3, 0, 0);
    checks++;
    if (timed_out || obs_data.size() != 2 || samp_cnt.size() != 2) begin
      failures++;
      $display("FAIL bp_count: results=%0d timeout=%0b, want 2", obs_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_data[i] !== -24'sd9 || samp_cnt[i] != 3 || obs_idx[i] != i) begin
          failures++;
          $display("FAIL bp_point%0d: data=%0d samples=%0d idx=%0d, want -9 3 %0d", i, obs_data[i], samp_cnt[i], obs_idx[i], i);
        end
      end
    end
    checks++;
    if (stall_bad != 0 || rv_seen != 16) begin
      failures++;
      $display("FAIL bp_stall: unstable=%0d valid_cycles=%0d, want 0 16", stall_bad, rv_seen);
    end
  endtask

  task automatic test_edges;
    run_sweep(32'd5, 32'd5, 0, 3, 2, 0, 0, 0, 1, 0, 0);
    checks++;
    if (done_cnt != 1 || done_cyc != 1 || src_en_seen || timed_out) begin
      failures++;
      $display("FAIL zero_points: done_cnt=%0d done_cyc=%0d src_en_seen=%0b, want 1 1 0", done_cnt, done_cyc, src_en_seen);
    end
    run_sweep(32'd100, 32'd1, 2, 0, 0, 0, 0, 0, 11, 0, 0);
    checks++;
    if (samp_cnt.size() != 2 || samp_cnt[0] != 1 || samp_cnt[1] != 1 || obs_data.size() != 2) begin
      failures++;
      $display("FAIL navg_zero: points=%0d results=%0d, want 2 points of 1 sample", samp_cnt.size(), obs_data.size());
    end else begin
      checks++;
      if (obs_data[0] !== 24'sd11 || obs_data[1] !== 24'sd11) begin
        failures++;
        $display("FAIL navg_zero_sum: got %0d %0d, want 11 11", obs_data[0], obs_data[1]);
      end
    end
    checks++;
    if (first_meas_cyc != 3 || done_cyc != 9) begin
      failures++;
      $display("FAIL settle_zero: meas_rise=%0d done_cyc=%0d, want 3 9", first_meas_cyc, done_cyc);
    end
  endtask

  task automatic test_wrap;
    run_sweep(32'hFFFF_FF9C, 32'd150, 2, 1, 1, 0, 0, 0, 2, 0, 0);
    checks++;
    if (obs_freq.size() != 2 || obs_freq[0] !== 32'hFFFF_FF9C || obs_freq[1] !== 32'd50) begin
      failures++;
      $display("FAIL wrap_freq: results=%0d second=%0d, want 2 results second 50", obs_freq.size(),
               (obs_freq.size() > 1) ? obs_freq[1] : 0);
    end
  endtask

  task automatic test_random;
    logic [FW-1:0] fs, fst, ef;
    int np, s, na, neff;
    for (int it = 0; it < 5; it++) begin
      fs = $urandom; fst = $urandom; np = $urandom_range(1, 4);
      s = $urandom_range(0, 5); na = $urandom_range(0, 6);
      neff = (na == 0) ? 1 : na;
      run_sweep(fs, fst, np, s, na, 2, 2, 0, 0, 1, 0);
      checks++;
      if (timed_out || obs_data.size() != np || exp_sum.size() != np || done_cnt != 1 || stall_bad != 0) begin
        failures++;
        $display("FAIL rand%0d_sweep: results=%0d points=%0d done=%0d unstable=%0d timeout=%0b, want %0d %0d 1 0 0",
                 it, obs_data.size(), exp_sum.size(), done_cnt, stall_bad, timed_out, np, np);
      end else begin
        for (int i = 0; i < np; i++) begin
          ef = fs + FW'(i) * fst;
          checks++;
          if (longint'(obs_data[i]) != exp_sum[i] || samp_cnt[i] != neff || obs_idx[i] != i || obs_freq[i] !== ef) begin
            failures++;
            $display("FAIL rand%0d_point%0d: data=%0d samples=%0d idx=%0d freq=%0h, want %0d %0d %0d %0h",
                     it, i, obs_data[i], samp_cnt[i], obs_idx[i], obs_freq[i], exp_sum[i], neff, i, ef);
          end
        end
      end
    end
  endtask

  task automatic test_abort;
    run_sweep(32'd4000, 32'd10, 3, 2, 8, 0, 0, 0, 1, 0, 1);
    checks++;
    if (!post_abort_clear || done_cnt != 0 || rv_seen != 0 || timed_out) begin
      failures++;
      $display("FAIL abort_meas: cleared=%0b done_cnt=%0d valid_cycles=%0d, want 1 0 0", post_abort_clear, done_cnt, rv_seen);
    end
    run_sweep(32'd4000, 32'd10, 3, 1, 2, 0, 0, 0, 4, 0, 0);
    checks++;
    if (obs_freq.size() != 3 || obs_freq[0] !== 32'd4000 || obs_data[0] !== 24'sd8 || done_cnt != 1) begin
      failures++;
      $display("FAIL abort_restart: results=%0d done_cnt=%0d, want 3 results from 4000 sum 8 and 1 done", obs_freq.size(), done_cnt);
    end
    @(negedge clk);
    n_points = 10'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (busy || done || src_en) begin
        failures++;
        $display("FAIL abort_with_start%0d: busy=%0b done=%0b src_en=%0b, want 0", c, busy, done, src_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    f_start = 32'd777; f_step = 32'd1; n_points = 10'd2; settle_cycles = 16'd20; n_avg = 8'd1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (!busy || !src_en || src_freq !== 32'd777) begin
      failures++;
      $display("FAIL reset_mid_pre: busy=%0b src_en=%0b src_freq=%0d, want 1 1 777", busy, src_en, src_freq);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({src_freq, src_en, meas_req, res_valid, res_data, res_index, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async: src_freq=%0d src_en=%0b busy=%0b, want all 0", src_freq, src_en, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (busy || src_en) begin
        failures++;
        $display("FAIL reset_mid_idle%0d: busy=%0b src_en=%0b, want 0", c, busy, src_en);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_backpressure;
    test_edges;
    test_wrap;
    test_random;
    test_abort;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
